// File: rtl/branch_exec_pipe_pkg.sv
// Branch execution pipe shared definitions.
// Op encoding, funct3 codes and the stage payload.
package branch_exec_pipe_pkg;

  localparam int BR_XLEN  = 32;
  localparam int BR_TAG_W = 4;

  localparam logic [1:0] BR_COND = 2'b00;
  localparam logic [1:0] BR_ILL  = 2'b01;
  localparam logic [1:0] BR_JAL  = 2'b10;
  localparam logic [1:0] BR_JALR = 2'b11;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  typedef struct packed {
    logic [BR_TAG_W-1:0] tag;
    logic [4:0]          rd;
    logic [BR_XLEN-1:0]  data;
    logic [BR_XLEN-1:0]  next_pc;
    logic                taken;
    logic                pred_taken;
    logic [BR_XLEN-1:0]  pred_pc;
    logic                illegal;
  } br_payload_t;

  function automatic logic br_mispredict(
    input br_payload_t p
  );
    return !p.illegal &&
      ((p.taken != p.pred_taken) ||
       (p.next_pc != p.pred_pc));
  endfunction

  function automatic logic br_misaligned(
    input br_payload_t p,
    input logic        allow_c
  );
    return p.taken && !allow_c && p.next_pc[1];
  endfunction

endpackage

// File: rtl/branch_exec_pipe_resolve.sv
// Combinational branch resolution.
// Decodes the op and computes direction, target and link.
module branch_resolve
  import branch_exec_pipe_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [4:0]      op,
  input  logic [XLEN-1:0] src1,
  input  logic [XLEN-1:0] src2,
  input  logic [XLEN-1:0] imm,
  input  logic [XLEN-1:0] pc,
  output logic            taken,
  output logic [XLEN-1:0] next_pc,
  output logic [XLEN-1:0] link,
  output logic            is_jump,
  output logic            illegal
);

  logic [XLEN-1:0] seq_pc;
  logic [XLEN-1:0] br_pc;
  logic [XLEN-1:0] jr_sum;
  logic [XLEN-1:0] jr_pc;
  logic            eq;
  logic            lt;
  logic            ltu;

  assign seq_pc = pc + XLEN'(4);
  assign br_pc  = pc + imm;
  assign jr_sum = src1 + imm;
  assign jr_pc  = jr_sum & ~XLEN'(1);
  assign eq     = (src1 == src2);
  assign lt     = ($signed(src1) < $signed(src2));
  assign ltu    = (src1 < src2);

  // Decode op class, then funct3 for conditional branches
  always_comb begin
    taken   = 1'b0;
    illegal = 1'b0;
    is_jump = 1'b0;
    next_pc = seq_pc;
    unique case (1'b1)
      (op[4:3] == BR_JAL): begin
        is_jump = 1'b1;
        taken   = 1'b1;
        next_pc = br_pc;
      end
      (op[4:3] == BR_JALR): begin
        is_jump = 1'b1;
        taken   = 1'b1;
        next_pc = jr_pc;
      end
      (op[4:3] == BR_COND): begin
        unique case (op[2:0])
          F3_BEQ:  taken = eq;
          F3_BNE:  taken = !eq;
          F3_BLT:  taken = lt;
          F3_BGE:  taken = !lt;
          F3_BLTU: taken = ltu;
          F3_BGEU: taken = !ltu;
          default: illegal = 1'b1;
        endcase
        if (taken) next_pc = br_pc;
      end
      default: illegal = 1'b1;
    endcase
  end

  assign link = is_jump ? seq_pc : '0;

endmodule

// File: rtl/branch_exec_pipe.sv
// Pipelined branch execution unit.
// Valid/ready on both sides, flush, mispredict detection.
module branch_exec_pipe
  import branch_exec_pipe_pkg::*;
#(
  parameter int XLEN    = BR_XLEN,
  parameter int TAG_W   = BR_TAG_W,
  parameter int STAGES  = 1,
  parameter int ALLOW_C = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [4:0]       in_op,
  input  logic [4:0]       in_rd,
  input  logic [XLEN-1:0]  in_src1,
  input  logic [XLEN-1:0]  in_src2,
  input  logic [XLEN-1:0]  in_imm,
  input  logic [XLEN-1:0]  in_pc,
  input  logic             in_pred_taken,
  input  logic [XLEN-1:0]  in_pred_pc,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [TAG_W-1:0] out_tag,
  output logic [4:0]       out_rd,
  output logic [XLEN-1:0]  out_data,
  output logic [XLEN-1:0]  out_next_pc,
  output logic             out_taken,
  output logic             out_mispredict,
  output logic             out_misaligned,
  output logic             out_illegal
);

  localparam logic ALLOW = (ALLOW_C != 0);

  // The payload struct is sized by the package
  if (XLEN != BR_XLEN || TAG_W != BR_TAG_W) begin : g_bad_w
    $error("XLEN/TAG_W must match branch_exec_pipe_pkg");
  end
  if (STAGES != 1 && STAGES != 2) begin : g_bad_s
    $error("STAGES must be 1 or 2");
  end

  logic            r_taken;
  logic            r_is_jump;
  logic            r_illegal;
  logic [XLEN-1:0] r_next_pc;
  logic [XLEN-1:0] r_link;

  logic            accept;
  logic            out_free;
  logic            nxt_valid;
  br_payload_t     pay_in;
  br_payload_t     nxt_pay;

  branch_resolve #(.XLEN(XLEN)) u_resolve (
    .op      (in_op),
    .src1    (in_src1),
    .src2    (in_src2),
    .imm     (in_imm),
    .pc      (in_pc),
    .taken   (r_taken),
    .next_pc (r_next_pc),
    .link    (r_link),
    .is_jump (r_is_jump),
    .illegal (r_illegal)
  );

  // Pack the resolved op; only jumps write rd
  always_comb begin
    pay_in            = '0;
    pay_in.tag        = in_tag;
    pay_in.rd         = r_is_jump ? in_rd : 5'd0;
    pay_in.data       = r_link;
    pay_in.next_pc    = r_next_pc;
    pay_in.taken      = r_taken;
    pay_in.pred_taken = in_pred_taken;
    pay_in.pred_pc    = in_pred_pc;
    pay_in.illegal    = r_illegal;
  end

  assign out_free = !out_valid || out_ready;
  assign accept   = in_valid && in_ready && !flush;

  if (STAGES == 2) begin : g_two
    logic        s1_valid;
    br_payload_t s1_q;

    assign in_ready  = !s1_valid || out_free;
    assign nxt_valid = s1_valid;
    assign nxt_pay   = s1_q;

    // Stage 1: hold the resolved op until the output stage frees
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        s1_valid <= 1'b0;
        s1_q     <= '0;
      end else if (flush) begin
        s1_valid <= 1'b0;
      end else if (in_ready) begin
        s1_valid <= accept;
        if (accept) s1_q <= pay_in;
      end
    end
  end else begin : g_one
    assign in_ready  = out_free;
    assign nxt_valid = accept;
    assign nxt_pay   = pay_in;
  end

  // Output stage: flags are derived as the op enters it
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid      <= 1'b0;
      out_tag        <= '0;
      out_rd         <= '0;
      out_data       <= '0;
      out_next_pc    <= '0;
      out_taken      <= 1'b0;
      out_mispredict <= 1'b0;
      out_misaligned <= 1'b0;
      out_illegal    <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (out_free) begin
      out_valid <= nxt_valid;
      if (nxt_valid) begin
        out_tag        <= nxt_pay.tag;
        out_rd         <= nxt_pay.rd;
        out_data       <= nxt_pay.data;
        out_next_pc    <= nxt_pay.next_pc;
        out_taken      <= nxt_pay.taken;
        out_mispredict <= br_mispredict(nxt_pay);
        out_misaligned <= br_misaligned(nxt_pay, ALLOW);
        out_illegal    <= nxt_pay.illegal;
      end
    end
  end

endmodule
